// File: rtl/mult_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH      = 32;
    localparam int unsigned MULT_REG_ADDR_W = 5;
    localparam int unsigned MULT_RUN_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_unit.sv
// Iterative 32x32 shift-add multiplier committing the low product word to the register file.
// Optional macro MULT_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module mult_unit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH      = MULT_WIDTH,
    parameter int unsigned REG_ADDR_W = MULT_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      OpA,
    input  logic [WIDTH-1:0]      OpB,
    input  logic [REG_ADDR_W-1:0] Dest,
    output logic                  busy,
    output logic [WIDTH-1:0]      WriteData,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic                  RegWrite
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    mult_state_t           r_state;
    logic [WIDTH-1:0]      r_acc_a;
    logic [WIDTH-1:0]      r_acc_b;
    logic [WIDTH-1:0]      r_product;
    logic [CNT_W-1:0]      r_count;
    logic [REG_ADDR_W-1:0] r_dest;

    logic [WIDTH-1:0]      w_product_next;
    logic                  w_done;

    assign w_product_next = r_acc_b[0] ? (r_product + r_acc_a) : r_product;

`ifdef MULT_EARLY_EXIT_EN
    assign w_done = (r_count == CNT_W'(WIDTH - 1)) || ((r_acc_b >> 1) == '0);
`else
    assign w_done = (r_count == CNT_W'(WIDTH - 1));
`endif

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_acc_a       <= '0;
            r_acc_b       <= '0;
            r_product     <= '0;
            r_count       <= '0;
            r_dest        <= '0;
            WriteData     <= '0;
            WriteRegister <= '0;
            RegWrite      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc_a   <= OpA;
                        r_acc_b   <= OpB;
                        r_dest    <= Dest;
                        r_product <= '0;
                        r_count   <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_product <= w_product_next;
                    r_acc_a   <= r_acc_a << 1;
                    r_acc_b   <= r_acc_b >> 1;
                    r_count   <= r_count + 1'b1;
                    if (w_done) begin
                        // Outputs are registered so the write strobe lines up with WB.
                        r_state       <= WB;
                        RegWrite      <= 1'b1;
                        WriteData     <= w_product_next;
                        WriteRegister <= r_dest;
                    end
                end
                WB: begin
                    RegWrite <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    RegWrite <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: scoreboard of expected writes plus a register-file model.
module tb_mult_unit;
    import mult_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [4:0]  Dest;
    logic        busy;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] rf[32];
    int          errors = 0;
    int          checks = 0;

    mult_unit #(
        .WIDTH      (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .OpA           (OpA),
        .OpB           (OpB),
        .Dest          (Dest),
        .busy          (busy),
        .WriteData     (WriteData),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
    end

    // Register file model: r0 is hardwired, writes land on the edge ending WB.
    always @(posedge clk) begin
        if (reset_n === 1'b1 && RegWrite === 1'b1 && WriteRegister != 5'd0)
            rf[WriteRegister] <= WriteData;
    end

    // Every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && RegWrite === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got r%0d=%h, required no write",
                         WriteRegister, WriteData);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (WriteData !== e.data || WriteRegister !== e.rd) begin
                    errors++;
                    $display("FAIL scoreboard_write: got r%0d=%h, required r%0d=%h",
                             WriteRegister, WriteData, e.rd, e.data);
                end
            end
        end
    end

    // Edge index (E0 = accept) at which the register file captures the result.
    function automatic int exp_lat(logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        return h + 2;
`else
        return MULT_RUN_CYCLES + 1;
`endif
    endfunction

    // Drives one request; optionally pulses start or asserts reset at a given edge.
    // wr_edge is the edge at which the write commits, or -1 if none was seen.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                         input int pulse_edge, input int reset_edge, output int wr_edge);
        int   edges;
        logic seen;
        logic [31:0] p;
        p = a * b;
        if (reset_edge == 0) sb.push_back('{data: p, rd: d});
        start = 1'b1;
        OpA   = a;
        OpB   = b;
        Dest  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        OpA   = $urandom;
        OpB   = $urandom;
        Dest  = 5'($urandom);
        edges = 0;
        seen  = 1'b0;
        wr_edge = -1;
        while (!seen && edges < 100) begin
            if (edges + 1 == pulse_edge) begin
                start = 1'b1;
                OpA   = 32'd9;
                OpB   = 32'd9;
                Dest  = 5'd5;
            end else begin
                start = 1'b0;
            end
            reset_n = (edges + 1 == reset_edge) ? 1'b0 : 1'b1;
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
            if (reset_n == 1'b0) begin
                reset_n = 1'b1;
                return;
            end
            if (RegWrite === 1'b1) seen = 1'b1;
        end
        if (seen) wr_edge = edges + 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        OpA     = 32'h1234_5678;
        OpB     = 32'h0000_0003;
        Dest    = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++; $display("FAIL reset_regwrite: got %b, required 0", RegWrite);
        end
        checks++;
        if (WriteData !== 32'd0) begin
            errors++; $display("FAIL reset_wdata: got %h, required 0", WriteData);
        end
        checks++;
        if (WriteRegister !== 5'd0) begin
            errors++; $display("FAIL reset_wreg: got %0d, required 0", WriteRegister);
        end
        reset_n = 1'b1;
        start   = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b, required 0", busy); end
    endtask

    task automatic test_basic();
        int wr;
        issue(32'd3, 32'd5, 5'd7, 0, 0, wr);
        checks++;
        if (wr != exp_lat(32'd5)) begin
            errors++; $display("FAIL basic_latency: got E%0d, required E%0d", wr, exp_lat(32'd5));
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_wb: got %b, required 1", busy); end
        @(posedge clk);
        #1;
        checks++;
        if (rf[7] !== 32'd15) begin errors++; $display("FAIL basic_rf7: got %h, required 0000000f", rf[7]); end
        checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got RegWrite=%b busy=%b, required 0 0", RegWrite, busy);
        end
        checks++;
        if (WriteData !== 32'd15 || WriteRegister !== 5'd7) begin
            errors++;
            $display("FAIL basic_hold: got r%0d=%h, required r7=0000000f", WriteRegister, WriteData);
        end
    endtask

    task automatic test_overflow();
        int wr;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 0, wr);
        @(posedge clk);
        #1;
        checks++;
        if (rf[1] !== 32'h0000_0001) begin
            errors++; $display("FAIL overflow_all_ones: got %h, required 00000001", rf[1]);
        end
        issue(32'h0102_0408, 32'h0000_001F, 5'd2, 0, 0, wr);
        @(posedge clk);
        #1;
        checks++;
        if (rf[2] !== 32'h1F3E_7CF8) begin
            errors++; $display("FAIL overflow_pattern: got %h, required 1f3e7cf8", rf[2]);
        end
    endtask

    task automatic test_busy_ignore();
        int wr;
        int lat;
        lat = exp_lat(32'd3);
        issue(32'd2, 32'd3, 5'd4, (lat > 10) ? 10 : lat - 1, 0, wr);
        checks++;
        if (wr != lat) begin
            errors++; $display("FAIL busy_latency: got E%0d, required E%0d", wr, lat);
        end
        @(posedge clk);
        #1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (rf[4] !== 32'd6 || rf[5] !== 32'd0) begin
            errors++; $display("FAIL busy_ignore: got r4=%h r5=%h, required r4=00000006 r5=0", rf[4], rf[5]);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int wr;
        int lat;
        lat = exp_lat(32'd7);
        issue(32'd7, 32'd7, 5'd3, 0, (lat > 15) ? 15 : lat - 1, wr);
        checks++;
        if (wr != -1 || busy !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: got wr=%0d busy=%b RegWrite=%b, required -1 0 0",
                     wr, busy, RegWrite);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (rf[3] !== 32'd0) begin errors++; $display("FAIL reset_mid_nowrite: got %h, required 0", rf[3]); end
        issue(32'd2, 32'd2, 5'd3, 0, 0, wr);
        @(posedge clk);
        #1;
        checks++;
        if (rf[3] !== 32'd4) begin errors++; $display("FAIL reset_mid_fresh: got %h, required 00000004", rf[3]); end
    endtask

    task automatic test_latency_cases();
        logic [31:0] bs[4];
        int wr;
        bs[0] = 32'h0000_0001;
        bs[1] = 32'h8000_0000;
        bs[2] = 32'h0000_0010;
        bs[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            issue(32'h0000_0ABC, bs[i], 5'(10 + i), 0, 0, wr);
            checks++;
            if (wr != exp_lat(bs[i])) begin
                errors++;
                $display("FAIL latency_opb_%h: got E%0d, required E%0d", bs[i], wr, exp_lat(bs[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_dest_zero();
        int wr;
        issue(32'd6, 32'd7, 5'd0, 0, 0, wr);
        checks++;
        if (wr != exp_lat(32'd7) || WriteData !== 32'd42) begin
            errors++;
            $display("FAIL dest_zero: got E%0d data=%h, required E%0d data=0000002a",
                     wr, WriteData, exp_lat(32'd7));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        OpA     = '0;
        OpB     = '0;
        Dest    = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_latency_cases();
        test_dest_zero();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
